// File: rtl/cphy_map_pkg.sv
// cphy_map_pkg: symbol types, sync word, FSM states and the 16-bit to 7-symbol mapping
package cphy_map_pkg;
  typedef struct packed {
    logic flip;
    logic rot;
    logic pol;
  } sym_t;
  typedef sym_t [6:0] word_t;
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
  localparam word_t SYNC_WORD = {3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};
  // Payload bits fill the unflipped symbols in ascending order; double-flip pairs are ranked lexicographically.
  function automatic word_t cphy_map16(input logic [15:0] d);
    logic [5:0] hi;
    logic [5:0] sel;
    logic [6:0] m;
    logic [31:0] v;
    logic [4:0] j;
    word_t w;
    hi = d[15:10];
    sel = '0;
    m = '0;
    v = {18'b0, d[13:0]};
    if (hi >= 6'h2C) begin
      sel = hi - 6'h2C;
      v = {22'b0, d[9:0]};
      for (int a = 0; a < 6; a++)
        for (int b = a + 1; b < 7; b++)
          if (int'(sel) == a * (13 - a) / 2 + b - a - 1) begin
            m[a] = 1'b1;
            m[b] = 1'b1;
          end
    end else if (hi >= 6'h10) begin
      sel = hi - 6'h10;
      m[sel[4:2]] = 1'b1;
      v = {20'b0, sel[1:0], d[9:0]};
    end
    j = '0;
    for (int k = 0; k < 7; k++) begin
      w[k] = m[k] ? 3'b100 : {1'b0, v[j + 5'd1], v[j]};
      j = m[k] ? j : j + 5'd2;
    end
    return w;
  endfunction
endpackage

// File: rtl/cphy_word_fifo.sv
// cphy_word_fifo: synchronous first-word-fall-through FIFO with full/empty/level
module cphy_word_fifo #(
  parameter int W = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign full_o = cnt_q == (AW + 1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign level_o = cnt_q;
  assign dout_o = mem_q[rd_q];
  assign wr = push_i && !full_o;
  assign rd = pop_i && !empty_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) mem_q[wr_q] <= din_i;
      wr_q <= wr ? wr_q + 1'b1 : wr_q;
      rd_q <= rd ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + (AW + 1)'(wr) - (AW + 1)'(rd);
    end
  end
endmodule

// File: rtl/cphy_stream_mapper.sv
// cphy_stream_mapper: buffers 16-bit words and serialises them as C-PHY symbols with optional sync insertion
module cphy_stream_mapper
  import cphy_map_pkg::*;
#(
  parameter int SYM_PER_CYC = 1,
  parameter int FIFO_DEPTH = 4,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [15:0]                   in_data,
  input  logic                          in_sop,
  output logic                          sym_valid,
  input  logic                          sym_ready,
  output logic [SYM_PER_CYC-1:0]        sym_flip,
  output logic [SYM_PER_CYC-1:0]        sym_rot,
  output logic [SYM_PER_CYC-1:0]        sym_pol,
  output logic                          sym_last,
  output logic                          sym_is_sync,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  state_t state_q, state_d;
  word_t cur_q, cur_d;
  logic [15:0] hold_q, hold_d;
  logic [2:0] idx_q, idx_d;
  logic sym_valid_q, sym_last_q, sym_is_sync_q;
  logic [SYM_PER_CYC-1:0] sym_flip_q, sym_rot_q, sym_pol_q;
  logic [SYM_PER_CYC-1:0] beat_flip, beat_rot, beat_pol;
  logic [16:0] head;
  logic full, empty, pop, adv, xfer, last_beat;
  cphy_word_fifo #(.W(17), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(in_valid && in_ready),
    .din_i({in_sop, in_data}),
    .pop_i(pop),
    .dout_o(head),
    .full_o(full),
    .empty_o(empty),
    .level_o(fifo_level)
  );
  assign in_ready = !full && !rst;
  // The FSM stage feeds the output register, which only refills when empty or being accepted.
  assign adv = !sym_valid_q || sym_ready;
  assign xfer = state_q != IDLE && adv;
  assign last_beat = (SYM_PER_CYC == 7) || (idx_q == 3'd0);
  assign pop = !empty && (state_q == IDLE || (state_q == DATA && xfer && last_beat));
  if (SYM_PER_CYC == 7) begin : g_par
    always_comb
      for (int k = 0; k < SYM_PER_CYC; k++) begin
        beat_flip[k] = cur_q[k].flip;
        beat_rot[k] = cur_q[k].rot;
        beat_pol[k] = cur_q[k].pol;
      end
  end else begin : g_ser
    assign beat_flip = cur_q[idx_q].flip;
    assign beat_rot = cur_q[idx_q].rot;
    assign beat_pol = cur_q[idx_q].pol;
  end
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    hold_d = hold_q;
    idx_d = xfer ? (last_beat ? 3'd6 : idx_q - 3'd1) : idx_q;
    if (xfer && last_beat && state_q == SYNC) begin
      state_d = DATA;
      cur_d = cphy_map16(hold_q);
    end
    if (xfer && last_beat && state_q == DATA) state_d = IDLE;
    if (pop) begin
      idx_d = 3'd6;
      state_d = (SYNC_EN && head[16]) ? SYNC : DATA;
      cur_d = (SYNC_EN && head[16]) ? SYNC_WORD : cphy_map16(head[15:0]);
      hold_d = head[15:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      hold_q <= '0;
      idx_q <= 3'd6;
      sym_valid_q <= 1'b0;
      sym_flip_q <= '0;
      sym_rot_q <= '0;
      sym_pol_q <= '0;
      sym_last_q <= 1'b0;
      sym_is_sync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      hold_q <= hold_d;
      idx_q <= idx_d;
      if (adv) sym_valid_q <= state_q != IDLE;
      if (xfer) begin
        sym_flip_q <= beat_flip;
        sym_rot_q <= beat_rot;
        sym_pol_q <= beat_pol;
        sym_last_q <= state_q == DATA && last_beat;
        sym_is_sync_q <= state_q == SYNC;
      end
    end
  end
  assign sym_valid = sym_valid_q;
  assign sym_flip = sym_flip_q;
  assign sym_rot = sym_rot_q;
  assign sym_pol = sym_pol_q;
  assign sym_last = sym_last_q;
  assign sym_is_sync = sym_is_sync_q;
endmodule
